// File: rtl/add43_pkg.sv
// Shared constants, state encoding and beat-merge helper for the 43-bit beat loader.
package add43_pkg;

  localparam int unsigned WIDTH  = 43;
  localparam int unsigned BEAT   = 16;
  localparam int unsigned NBEATS = (WIDTH + BEAT - 1) / BEAT;
  localparam int unsigned CNT_W  = $clog2(NBEATS);
  localparam int unsigned WIDX_W = $clog2(WIDTH);
  localparam int unsigned BIDX_W = $clog2(BEAT);

  typedef enum logic [1:0] {
    ST_LOAD_A = 2'd0,
    ST_LOAD_B = 2'd1,
    ST_ADD    = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  typedef struct packed {
    logic             cout;
    logic [WIDTH-1:0] sum;
  } result_t;

  // Overwrite the slice of op selected by beat index idx; bits past WIDTH-1 are dropped.
  function automatic logic [WIDTH-1:0] beat_merge(input logic [WIDTH-1:0] op,
                                                  input logic [BEAT-1:0]  data,
                                                  input logic [CNT_W-1:0] idx);
    logic [WIDTH-1:0] res;
    res = op;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if ((i / BEAT) == 32'(idx)) res[WIDX_W'(i)] = data[BIDX_W'(i % BEAT)];
    end
    return res;
  endfunction

endpackage

// File: rtl/add43_beat_loader_if.sv
// Beat-input and result-output handshake bundle for add43_beat_loader.
interface add43_beat_loader_if;
  import add43_pkg::*;

  logic             i_valid;
  logic             o_ready;
  logic [BEAT-1:0]  i_data;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_busy;

  modport slave (
    input  i_valid, i_data, i_ready,
    output o_ready, o_valid, o_sum, o_cout, o_busy
  );

  modport master (
    output i_valid, i_data, i_ready,
    input  o_ready, o_valid, o_sum, o_cout, o_busy
  );

endinterface

// File: rtl/add43_beat_loader_csa.sv
// 43-bit carry-select adder: 11-bit blocks, each precomputing carry-in 0/1 results.
module csa_43bit (
  input  logic [42:0] i_a,
  input  logic [42:0] i_b,
  input  logic        i_cin,
  output logic [42:0] o_sum,
  output logic        o_cout
);

  localparam int unsigned W_TOT = 43;
  localparam int unsigned BLK   = 11;
  localparam int unsigned NBLK  = (W_TOT + BLK - 1) / BLK;

  logic [NBLK:0] w_c;

  assign w_c[0] = i_cin;

  for (genvar j = 0; j < NBLK; j++) begin : g_blk
    localparam int unsigned LO = j * BLK;
    localparam int unsigned W  = ((W_TOT - LO) < BLK) ? (W_TOT - LO) : BLK;

    logic [W:0] w_s0;
    logic [W:0] w_s1;

    assign w_s0 = {1'b0, i_a[LO+W-1:LO]} + {1'b0, i_b[LO+W-1:LO]};
    assign w_s1 = w_s0 + (W+1)'(1);

    // Late-arriving block carry only steers a mux.
    assign o_sum[LO+W-1:LO] = w_c[j] ? w_s1[W-1:0] : w_s0[W-1:0];
    assign w_c[j+1]         = w_c[j] ? w_s1[W]     : w_s0[W];
  end

  assign o_cout = w_c[NBLK];

endmodule

// File: rtl/add43_beat_loader.sv
// Collects two 43-bit operands from 16-bit LSB-first beats, adds them, and holds
// the registered sum/carry until the consumer takes it.
module add43_beat_loader
  import add43_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  add43_beat_loader_if.slave bus
);

  localparam logic [1:0] S_LOAD_A = ST_LOAD_A;
  localparam logic [1:0] S_LOAD_B = ST_LOAD_B;
  localparam logic [1:0] S_ADD    = ST_ADD;
  localparam logic [1:0] S_HOLD   = ST_HOLD;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_op_a;
  logic [WIDTH-1:0] r_op_b;
  result_t          r_res;
  logic             r_valid;
  logic             r_ready;
  logic             r_busy;

  logic             w_xfer;
  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_sum;
  logic             w_cout;

  // r_ready is only ever set in the load states, so a transfer implies loading.
  assign w_xfer   = bus.i_valid & r_ready;
  assign w_accept = r_valid & bus.i_ready;
  assign w_last   = (r_cnt == CNT_W'(NBEATS - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_LOAD_A: begin
        if (w_xfer) begin
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_LOAD_B;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_LOAD_B: begin
        if (w_xfer) begin
          if (w_last) begin
            w_cnt_nxt   = '0;
            w_state_nxt = S_ADD;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      end
      S_ADD: begin
        w_state_nxt = S_HOLD;
      end
      S_HOLD: begin
        if (w_accept) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_LOAD_A;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_LOAD_A;
      end
    endcase
  end

  // Handshake flags are decoded from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_LOAD_A;
      r_cnt   <= '0;
      r_valid <= 1'b0;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_valid <= (w_state_nxt == S_HOLD);
      r_ready <= (w_state_nxt == S_LOAD_A) || (w_state_nxt == S_LOAD_B);
      r_busy  <= !((w_state_nxt == S_LOAD_A) && (w_cnt_nxt == '0));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_op_a <= '0;
      r_op_b <= '0;
    end else if (w_xfer) begin
      if (r_state == S_LOAD_A) r_op_a <= beat_merge(r_op_a, bus.i_data, r_cnt);
      if (r_state == S_LOAD_B) r_op_b <= beat_merge(r_op_b, bus.i_data, r_cnt);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_res <= '0;
    end else if (r_state == S_ADD) begin
      r_res <= '{cout: w_cout, sum: w_sum};
    end
  end

  csa_43bit u_csa (
    .i_a    (r_op_a),
    .i_b    (r_op_b),
    .i_cin  (1'b0),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  assign bus.o_ready = r_ready;
  assign bus.o_valid = r_valid;
  assign bus.o_sum   = r_res.sum;
  assign bus.o_cout  = r_res.cout;
  assign bus.o_busy  = r_busy;

endmodule

// File: tb/tb_add43_beat_loader.sv
// Self-checking bench for add43_beat_loader: directed vectors, corner sequences, random adds.
module tb_add43_beat_loader;
  import add43_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  add43_beat_loader_if bus ();

  add43_beat_loader dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    string       name;
    logic [47:0] a;
    logic [47:0] b;
    logic [42:0] sum;
    logic        cout;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    check("valid_ready_excl", 64'(bus.o_valid & bus.o_ready), 64'd0);
  endtask

  task automatic send_beat(input logic [15:0] d, input int gaps);
    int t;
    for (int g = 0; g < gaps; g++) begin
      bus.i_valid = 1'b0;
      bus.i_data  = 16'($urandom);
      bus.i_ready = 1'($urandom_range(0, 1));
      step();
    end
    bus.i_ready = 1'b0;
    t = 0;
    while (!bus.o_ready && t < 20) begin
      step();
      t++;
    end
    check("ready_wait", 64'(bus.o_ready), 64'd1);
    bus.i_valid = 1'b1;
    bus.i_data  = d;
    step();
    bus.i_valid = 1'b0;
    bus.i_data  = 16'($urandom);
  endtask

  task automatic load_ops(input logic [47:0] a, input logic [47:0] b, input int maxgap);
    logic [95:0] all;
    all = {b, a};
    for (int k = 0; k < 6; k++) begin
      send_beat(all[16*k +: 16], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
      check("no_valid_in_load", 64'(bus.o_valid), 64'd0);
    end
  endtask

  task automatic get_result(output logic [42:0] s, output logic c);
    int t;
    t = 0;
    while (!bus.o_valid && t < 20) begin
      step();
      t++;
    end
    check("result_valid", 64'(bus.o_valid), 64'd1);
    s = bus.o_sum;
    c = bus.o_cout;
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    check("valid_drop", 64'(bus.o_valid), 64'd0);
    check("ready_back", 64'(bus.o_ready), 64'd1);
    check("idle_busy", 64'(bus.o_busy), 64'd0);
  endtask

  vec_t        vecs [5];
  logic [42:0] s;
  logic        c;
  logic [42:0] ra;
  logic [42:0] rb;
  logic [43:0] e;

  initial begin
    vecs[0] = '{"basic",      48'h0000_0000_0001, 48'h0000_0000_0001, 43'h2,           1'b0};
    vecs[1] = '{"full_carry", 48'h07FF_FFFF_FFFF, 48'h0000_0000_0001, 43'h0,           1'b1};
    vecs[2] = '{"ign_upper",  48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 43'h0,           1'b1};
    vecs[3] = '{"max_max",    48'h07FF_FFFF_FFFF, 48'h07FF_FFFF_FFFF, 43'h7FFFFFFFFFE, 1'b1};
    vecs[4] = '{"mixed",      48'h0123_4567_89AB, 48'h0000_0000_0055, 43'h12345678A00, 1'b0};

    bus.i_valid = 1'b0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;

    // Reset values
    #12;
    check("rst_valid", 64'(bus.o_valid), 64'd0);
    check("rst_sum",   64'(bus.o_sum),   64'd0);
    check("rst_cout",  64'(bus.o_cout),  64'd0);
    check("rst_busy",  64'(bus.o_busy),  64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_ready", 64'(bus.o_ready), 64'd1);

    // Directed vectors with exact latency checks
    for (int i = 0; i < 5; i++) begin
      load_ops(vecs[i].a, vecs[i].b, 0);
      check({vecs[i].name, "_add_valid"}, 64'(bus.o_valid), 64'd0);
      check({vecs[i].name, "_add_ready"}, 64'(bus.o_ready), 64'd0);
      check({vecs[i].name, "_add_busy"},  64'(bus.o_busy),  64'd1);
      step();
      check({vecs[i].name, "_hold_valid"}, 64'(bus.o_valid), 64'd1);
      get_result(s, c);
      check({vecs[i].name, "_sum"},  64'(s), 64'(vecs[i].sum));
      check({vecs[i].name, "_cout"}, 64'(c), 64'(vecs[i].cout));
    end

    // Backpressure: junk beats offered while the result is held
    load_ops(48'h0000_0000_0064, 48'h0000_0000_00C8, 0);
    step();
    bus.i_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus.i_data = 16'($urandom);
      step();
      check("bp_ready", 64'(bus.o_ready), 64'd0);
      check("bp_valid", 64'(bus.o_valid), 64'd1);
      check("bp_sum",   64'(bus.o_sum),   64'd300);
    end
    bus.i_ready = 1'b1;
    step();
    bus.i_ready = 1'b0;
    bus.i_valid = 1'b0;
    check("bp_accept_valid", 64'(bus.o_valid), 64'd0);
    check("bp_accept_ready", 64'(bus.o_ready), 64'd1);
    load_ops(48'h0000_0000_0003, 48'h0000_0000_0004, 0);
    get_result(s, c);
    check("bp_next_sum", 64'(s), 64'd7);

    // Gaps between beats
    load_ops(48'h0123_4567_89AB, 48'h0000_0000_0055, 3);
    get_result(s, c);
    check("gap_sum",  64'(s), 64'h12345678A00);
    check("gap_cout", 64'(c), 64'd0);

    // Reset in the middle of a load
    send_beat(16'hAAAA, 0);
    send_beat(16'hBBBB, 0);
    send_beat(16'hCCCC, 0);
    send_beat(16'hDDDD, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.o_valid), 64'd0);
    check("mid_rst_sum",   64'(bus.o_sum),   64'd0);
    check("mid_rst_cout",  64'(bus.o_cout),  64'd0);
    check("mid_rst_busy",  64'(bus.o_busy),  64'd0);
    @(posedge clk);
    #1;
    check("mid_rst_hold_valid", 64'(bus.o_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("mid_rst_ready", 64'(bus.o_ready), 64'd1);
    check("mid_rst_idle",  64'(bus.o_busy),  64'd0);
    load_ops(48'h0000_0000_0005, 48'h0000_0000_0007, 2);
    get_result(s, c);
    check("reload_sum",  64'(s), 64'd12);
    check("reload_cout", 64'(c), 64'd0);

    // Random operands against plain arithmetic
    for (int i = 0; i < 20; i++) begin
      ra = {11'($urandom), 32'($urandom)};
      rb = {11'($urandom), 32'($urandom)};
      e  = {1'b0, ra} + {1'b0, rb};
      load_ops({5'($urandom), ra}, {5'($urandom), rb}, 3);
      get_result(s, c);
      check("rand_sum",  64'(s), 64'(e[42:0]));
      check("rand_cout", 64'(c), 64'(e[43]));
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
